// File: rtl/wide_inv_bist.sv
// wide_inv_bist: self-test driver and checker for the wide_inv datapath.
// It waits for the DUT to report ready, then drives an 11-entry pattern ROM onto
// dut_d_in, each word held for HOLD_CYCLES cycles. Every returned word is checked
// against the bitwise inverse of the word driven DUT_LATENCY cycles earlier, and a
// pass/fail summary is reported.
//
// Parameters:
//   DUT_LATENCY   cycles from dut_d_in changing to the matching dut_d_out (0..7)
//   HOLD_CYCLES   cycles each pattern is held on dut_d_in (1..255)
// Ports:
//   clock         rising-edge clock
//   rst           asynchronous active-high reset
//   start         begin a run (sampled in IDLE or DONE)
//   dut_rdy       DUT ready; a drop while driving or draining aborts the run
//   dut_d_out     DUT response
//   dut_d_in      registered stimulus to the DUT
//   busy          high in WAIT_RDY, DRIVE and DRAIN
//   done          high in DONE
//   pass          done with no mismatches and no abort
//   aborted       the run ended early because dut_rdy fell
//   err_count     mismatching compare cycles, saturating at 255
//   first_err_idx pattern index of the first mismatch, 4'hF if none
module wide_inv_bist #(
  parameter int unsigned DUT_LATENCY = 1,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        start,
  input  logic        dut_rdy,
  input  logic [31:0] dut_d_out,
  output logic [31:0] dut_d_in,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        aborted,
  output logic [7:0]  err_count,
  output logic [3:0]  first_err_idx
);

  typedef enum logic [2:0] {StIdle, StWaitRdy, StDrive, StDrain, StDone} state_e;

  localparam logic [3:0] LastIdx   = 4'd10;
  localparam logic [3:0] NoErr     = 4'hF;
  localparam logic [7:0] LastHold  = 8'(HOLD_CYCLES - 1);
  localparam logic [2:0] LastDrain = (DUT_LATENCY == 0) ? 3'd0 : 3'(DUT_LATENCY - 1);

  function automatic logic [31:0] rom_word(input logic [3:0] idx);
    logic [31:0] w;
    unique case (idx)
      4'd0:    w = 32'h0000_0000;
      4'd1:    w = 32'hffff_ffff;
      4'd2:    w = 32'hffff_0000;
      4'd3:    w = 32'h0000_ffff;
      4'd4:    w = 32'h5555_5555;
      4'd5:    w = 32'haaaa_aaaa;
      4'd6:    w = 32'h1111_1111;
      4'd7:    w = 32'h2222_2222;
      4'd8:    w = 32'h4444_4444;
      4'd9:    w = 32'h8888_8888;
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  hold_q, hold_d;
  logic [2:0]  drain_q, drain_d;
  logic [31:0] din_q, din_d;
  logic [7:0]  err_q, err_d;
  logic [3:0]  first_q, first_d;
  logic        aborted_q, aborted_d;

  // Ready dropping while stimulus or responses are in flight ends the run.
  logic abort;
  assign abort = ((state_q == StDrive) || (state_q == StDrain)) && !dut_rdy;

  // Expect entry for the word currently visible on dut_d_in.
  logic        push_v;
  logic [31:0] push_e;
  logic [3:0]  push_i;
  assign push_v = (state_q == StDrive);
  assign push_e = ~din_q;  // din_q holds ROM[idx_q] throughout DRIVE
  assign push_i = idx_q;

  logic        tail_v;
  logic [31:0] tail_e;
  logic [3:0]  tail_i;

  if (DUT_LATENCY == 0) begin : g_no_pipe
    assign tail_v = push_v;
    assign tail_e = push_e;
    assign tail_i = push_i;
  end else begin : g_pipe
    logic        pv_q [DUT_LATENCY];
    logic [31:0] pe_q [DUT_LATENCY];
    logic [3:0]  pi_q [DUT_LATENCY];

    always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < int'(DUT_LATENCY); i++) begin
          pv_q[i] <= 1'b0;
          pe_q[i] <= '0;
          pi_q[i] <= '0;
        end
      end else begin
        pv_q[0] <= push_v & ~abort;
        pe_q[0] <= push_e;
        pi_q[0] <= push_i;
        for (int i = 1; i < int'(DUT_LATENCY); i++) begin
          pv_q[i] <= pv_q[i-1] & ~abort;
          pe_q[i] <= pe_q[i-1];
          pi_q[i] <= pi_q[i-1];
        end
      end
    end

    assign tail_v = pv_q[DUT_LATENCY-1];
    assign tail_e = pe_q[DUT_LATENCY-1];
    assign tail_i = pi_q[DUT_LATENCY-1];
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    drain_d   = drain_q;
    din_d     = 32'h0;
    err_d     = err_q;
    first_d   = first_q;
    aborted_d = aborted_q;

    // An aborting cycle flushes outstanding expects without checking them.
    if (tail_v && !abort && (dut_d_out != tail_e)) begin
      if (err_q != 8'hFF) err_d = err_q + 8'd1;
      if (first_q == NoErr) first_d = tail_i;
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          err_d     = 8'd0;
          first_d   = NoErr;
          aborted_d = 1'b0;
          state_d   = StWaitRdy;
        end
      end
      StWaitRdy: begin
        if (dut_rdy) begin
          state_d = StDrive;
          idx_d   = 4'd0;
          hold_d  = 8'd0;
          din_d   = rom_word(4'd0);
        end
      end
      StDrive: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = StDone;
        end else if (hold_q == LastHold) begin
          if (idx_q == LastIdx) begin
            drain_d = 3'd0;
            state_d = (DUT_LATENCY == 0) ? StDone : StDrain;
          end else begin
            idx_d  = idx_q + 4'd1;
            hold_d = 8'd0;
            din_d  = rom_word(idx_q + 4'd1);
          end
        end else begin
          hold_d = hold_q + 8'd1;
          din_d  = rom_word(idx_q);
        end
      end
      StDrain: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = StDone;
        end else if (drain_q == LastDrain) begin
          state_d = StDone;
        end else begin
          drain_d = drain_q + 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= 4'd0;
      hold_q    <= 8'd0;
      drain_q   <= 3'd0;
      din_q     <= 32'h0;
      err_q     <= 8'd0;
      first_q   <= NoErr;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      drain_q   <= drain_d;
      din_q     <= din_d;
      err_q     <= err_d;
      first_q   <= first_d;
      aborted_q <= aborted_d;
    end
  end

  assign dut_d_in      = din_q;
  assign busy          = (state_q == StWaitRdy) || (state_q == StDrive) || (state_q == StDrain);
  assign done          = (state_q == StDone);
  assign pass          = done && (err_q == 8'd0) && !aborted_q;
  assign aborted       = aborted_q;
  assign err_count     = err_q;
  assign first_err_idx = first_q;

endmodule

// File: tb/tb_wide_inv_bist.sv
// Bench for wide_inv_bist. Four instances (latency/hold = 1/2, 1/32, 0/2, 3/2) share
// start/rdy/rst; each faces a bench-side inverter with selectable latency and fault.
// A cycle-time model predicts every output from the pattern arithmetic.
module tb_wide_inv_bist;
  localparam int NI = 4;
  localparam logic [31:0] RomT [11] = '{32'h00000000, 32'hffffffff, 32'hffff0000,
    32'h0000ffff, 32'h55555555, 32'haaaaaaaa, 32'h11111111, 32'h22222222,
    32'h44444444, 32'h88888888, 32'h00000000};

  logic clock = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic rdy = 1'b0;
  always #5 clock = ~clock;

  logic [NI-1:0]       busy_v, done_v, pass_v, abort_v;
  logic [NI-1:0][7:0]  err_v;
  logic [NI-1:0][3:0]  first_v;
  logic [NI-1:0][31:0] din_v, dout_v;

  int ld_sel [NI];  // latency of the bench inverter
  int mode   [NI];  // 0 ideal, 1 bit0 stuck at 0, 2 passthrough
  int n_cmp = 0;
  int n_bad = 0;
  int done_at [NI];

  function automatic int h_of(input int g);
    return (g == 1) ? 32 : 2;
  endfunction
  function automatic int l_of(input int g);
    return (g == 3) ? 3 : ((g == 2) ? 0 : 1);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int unsigned Lat  = (g == 3) ? 3 : ((g == 2) ? 0 : 1);
    localparam int unsigned Hold = (g == 1) ? 32 : 2;
    logic [31:0] line_q [4];
    logic [31:0] raw;
    logic [31:0] resp;

    wide_inv_bist #(.DUT_LATENCY(Lat), .HOLD_CYCLES(Hold)) u_dut (
      .clock(clock), .rst(rst), .start(start), .dut_rdy(rdy),
      .dut_d_out(dout_v[g]), .dut_d_in(din_v[g]), .busy(busy_v[g]), .done(done_v[g]),
      .pass(pass_v[g]), .aborted(abort_v[g]), .err_count(err_v[g]),
      .first_err_idx(first_v[g])
    );

    always @(posedge clock) begin
      line_q[0] <= ~din_v[g];
      for (int k = 1; k < 4; k++) line_q[k] <= line_q[k-1];
    end

    always_comb begin
      raw = (ld_sel[g] == 0) ? ~din_v[g] : line_q[ld_sel[g]-1];
      case (mode[g])
        1:       resp = raw & 32'hffff_fffe;
        2:       resp = ~raw;
        default: resp = raw;
      endcase
    end
    assign dout_v[g] = resp;
  end

  // Word on dut_d_in x cycles after the first drive cycle of a run.
  function automatic logic [31:0] din_at(input int x, input int h);
    if (x >= 0 && x < 11 * h) return RomT[x / h];
    return 32'h0;
  endfunction

  function automatic logic [31:0] resp_at(input int x, input int h, input int md);
    logic [31:0] r;
    r = ~din_at(x, h);
    if (md == 1) r = r & 32'hffff_fffe;
    if (md == 2) r = ~r;
    return r;
  endfunction

  // Model: phase 0 idle/done, 1 waiting for rdy, 2 running (t = cycles since drive began).
  int m_phase [NI];
  int m_t     [NI];
  int m_err   [NI];
  int m_first [NI];
  bit m_done  [NI];
  bit m_abort [NI];

  always @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int g = 0; g < NI; g++) begin
        m_phase[g] <= 0;
        m_t[g]     <= 0;
        m_err[g]   <= 0;
        m_first[g] <= 15;
        m_done[g]  <= 1'b0;
        m_abort[g] <= 1'b0;
      end
    end else begin
      for (int g = 0; g < NI; g++) begin : m_step
        int p, t, e, f, h, l, w;
        bit d, a;
        p = m_phase[g]; t = m_t[g]; e = m_err[g]; f = m_first[g];
        d = m_done[g]; a = m_abort[g];
        h = h_of(g); l = l_of(g);
        if (p == 0) begin
          if (start) begin
            e = 0; f = 15; a = 1'b0; d = 1'b0; p = 1;
          end
        end else if (p == 1) begin
          if (rdy) begin
            p = 2; t = 0;
          end
        end else if (!rdy) begin
          a = 1'b1; d = 1'b1; p = 0;
        end else begin
          w = t - l;
          if (w >= 0 && w < 11 * h) begin
            if (resp_at(t - ld_sel[g], h, mode[g]) != ~RomT[w / h]) begin
              if (e < 255) e = e + 1;
              if (f == 15) f = w / h;
            end
          end
          t = t + 1;
          if (t == 11 * h + l) begin
            d = 1'b1; p = 0;
          end
        end
        m_phase[g] <= p; m_t[g] <= t; m_err[g] <= e; m_first[g] <= f;
        m_done[g] <= d; m_abort[g] <= a;
      end
    end
  end

  task automatic check(input string nm, input int g, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] at %0t: actual %h required %h", nm, g, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    for (int g = 0; g < NI; g++) begin : cmp_step
      int h;
      logic [31:0] e_din;
      h = h_of(g);
      e_din = (m_phase[g] == 2 && m_t[g] < 11 * h) ? RomT[m_t[g] / h] : 32'h0;
      check("busy", g, 32'(busy_v[g]), 32'(m_phase[g] != 0));
      check("done", g, 32'(done_v[g]), 32'(m_done[g]));
      check("pass", g, 32'(pass_v[g]), 32'(m_done[g] && m_err[g] == 0 && !m_abort[g]));
      check("aborted", g, 32'(abort_v[g]), 32'(m_abort[g]));
      check("err_count", g, 32'(err_v[g]), 32'(m_err[g]));
      check("first_err_idx", g, 32'(first_v[g]), 32'(m_first[g]));
      check("dut_d_in", g, din_v[g], e_din);
    end
  end

  // Pulses start, raises rdy at cycle rdy_at (0: rdy already high) and records the cycle
  // count at which each instance first shows done.
  task automatic do_run(input int rdy_at, input bit poke_start);
    int n;
    bit all;
    for (int g = 0; g < NI; g++) done_at[g] = -1;
    start = 1'b1;
    n = 0;
    all = 1'b0;
    while (!all && n < 500) begin
      @(posedge clock);
      #1;
      n++;
      if (n == 1) start = 1'b0;
      if (n == rdy_at) rdy = 1'b1;
      if (poke_start && n == 10) start = 1'b1;
      if (poke_start && n == 11) start = 1'b0;
      all = 1'b1;
      for (int g = 0; g < NI; g++) begin
        if (done_at[g] < 0 && done_v[g]) done_at[g] = n;
        if (done_at[g] < 0) all = 1'b0;
      end
    end
    if (!all) check("run_timeout", 0, 32'(n), 32'd0);
    rdy = 1'b0;
  endtask

  initial begin
    for (int g = 0; g < NI; g++) begin
      ld_sel[g] = l_of(g);
      mode[g] = 0;
    end
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", 0, 32'(busy_v[0]), 32'd0);
    check("rst_done", 0, 32'(done_v[0]), 32'd0);
    check("rst_pass", 0, 32'(pass_v[0]), 32'd0);
    check("rst_first", 0, 32'(first_v[0]), 32'hF);
    rst = 1'b0;
    @(posedge clock);
    #1;

    // Ideal inverters everywhere except instance 1, which passes d_in straight through.
    mode[1] = 2;
    do_run(5, 1'b0);
    check("done_cycle", 0, 32'(done_at[0]), 32'd29);
    check("done_cycle", 1, 32'(done_at[1]), 32'd359);
    check("done_cycle", 2, 32'(done_at[2]), 32'd28);
    check("done_cycle", 3, 32'(done_at[3]), 32'd31);
    check("ideal_pass", 0, 32'(pass_v[0]), 32'd1);
    check("ideal_err", 0, 32'(err_v[0]), 32'd0);
    check("ideal_first", 0, 32'(first_v[0]), 32'hF);
    check("lat0_pass", 2, 32'(pass_v[2]), 32'd1);
    check("lat3_pass", 3, 32'(pass_v[3]), 32'd1);
    check("sat_err", 1, 32'(err_v[1]), 32'd255);
    check("sat_first", 1, 32'(first_v[1]), 32'd0);
    check("sat_pass", 1, 32'(pass_v[1]), 32'd0);
    check("model_sat", 1, 32'(m_err[1]), 32'd255);

    // Bit 0 stuck low on instance 0; latency off by one on instances 2 and 3.
    repeat (3) @(posedge clock);
    #1;
    mode[0] = 1; mode[1] = 0; ld_sel[2] = 1; ld_sel[3] = 4;
    do_run(5, 1'b0);
    check("stuck_err", 0, 32'(err_v[0]), 32'd14);
    check("model_stuck", 0, 32'(m_err[0]), 32'd14);
    check("stuck_first", 0, 32'(first_v[0]), 32'd0);
    check("stuck_pass", 0, 32'(pass_v[0]), 32'd0);
    check("restart_pass", 1, 32'(pass_v[1]), 32'd1);
    check("lat_off_err", 2, 32'(err_v[2] != 8'd0), 32'd1);
    check("lat_off_err", 3, 32'(err_v[3] != 8'd0), 32'd1);

    // rdy drops in the first cycle of pattern 4 on instance 0.
    repeat (3) @(posedge clock);
    #1;
    mode[0] = 0; ld_sel[2] = 0; ld_sel[3] = 3;
    start = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      @(posedge clock);
      #1;
      if (n == 1) start = 1'b0;
      if (n == 5) rdy = 1'b1;
      if (n == 14) rdy = 1'b0;
    end
    check("abort_flag", 0, 32'(abort_v[0]), 32'd1);
    check("abort_done", 0, 32'(done_v[0]), 32'd1);
    check("abort_pass", 0, 32'(pass_v[0]), 32'd0);
    check("abort_din", 0, din_v[0], 32'h0);
    repeat (3) @(posedge clock);
    #1;
    do_run(5, 1'b0);
    check("after_abort_pass", 0, 32'(pass_v[0]), 32'd1);
    check("after_abort_flag", 0, 32'(abort_v[0]), 32'd0);
    check("after_abort_cycle", 0, 32'(done_at[0]), 32'd29);

    // Reset in the middle of DRIVE.
    repeat (2) @(posedge clock);
    #1;
    start = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clock);
      #1;
      if (n == 1) start = 1'b0;
      if (n == 5) rdy = 1'b1;
    end
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 0, 32'(busy_v[0]), 32'd0);
    check("mid_rst_din", 0, din_v[0], 32'h0);
    check("mid_rst_err", 0, 32'(err_v[0]), 32'd0);
    check("mid_rst_first", 0, 32'(first_v[0]), 32'hF);
    check("mid_rst_busy", 3, 32'(busy_v[3]), 32'd0);
    @(negedge clock);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clock);
    #1;

    // rdy already high with start; a start pulse mid-run must be ignored.
    rdy = 1'b1;
    do_run(0, 1'b1);
    check("rdy_first_cycle", 0, 32'(done_at[0]), 32'd25);
    check("rdy_first_cycle", 1, 32'(done_at[1]), 32'd355);
    check("rdy_first_cycle", 2, 32'(done_at[2]), 32'd24);
    check("rdy_first_cycle", 3, 32'(done_at[3]), 32'd27);
    check("post_rst_pass", 0, 32'(pass_v[0]), 32'd1);

    repeat (2) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
